window_write_fifo: RTL and testbench
====================================

Name: window_write_fifo

Overview:
- Stage directly downstream of the address-window decoder on the PicoRV32 look-ahead memory interface.
- Uses the decoder's hit strobe, re-qualified against the window bounds, to capture every CPU store into the 0x1000–0x3FFF window.
- Each captured store (address, data, byte strobes) is buffered in a show-ahead FIFO and presented to a peripheral consumer over a valid/ready handshake.
- Also keeps a saturating hit counter and a sticky overflow flag for software and debug visibility.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- ADDR_BASE, 32'h0000_1000, inclusive lower bound of the capture window.
- ADDR_LIMIT, 32'h0000_4000, exclusive upper bound of the capture window.
- CNT_W, 16, width of hit_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_byte_en  in  1  hit strobe from the address-window decoder.
- mem_la_write  in  1  PicoRV32 look-ahead write strobe.
- mem_la_addr  in  32  look-ahead address.
- mem_la_wdata  in  32  look-ahead write data.
- mem_la_wstrb  in  4  look-ahead byte strobes.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_addr  out  32  head entry address, word-aligned (bits [1:0] = 0).
- out_data  out  32  head entry data.
- out_strb  out  4  head entry byte strobes.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- hit_count  out  CNT_W  qualified writes seen, saturating.
- overflow  out  1  sticky; set when a qualified write is dropped.

Behaviour:
- Qualified write (qw), combinational, per cycle: in_byte_en && mem_la_write && mem_la_wstrb != 0 && ADDR_BASE <= mem_la_addr < ADDR_LIMIT. The explicit bounds check is mandatory; the decoder strobe alone is not trusted.
- Pop: out_valid && out_ready.
- Push: qw && (!full || pop). All decisions use the registered state at the start of the cycle.
- Push when full with a simultaneous pop: accepted; level stays DEPTH.
- Stored entry: {mem_la_addr[31:2],2'b00}, mem_la_wdata, mem_la_wstrb.
- Latency: a qw sampled at edge N into an empty FIFO gives out_valid=1 with that entry's fields after edge N (cycle N+1).
- Show-ahead FIFO: out_valid = !empty. out_addr, out_data and out_strb always reflect the head entry and stay stable while out_valid && !out_ready.
- Field values are don't-care when empty, except after reset, when they read 0.
- Ordering is strictly FIFO.
- level changes per cycle:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on both or neither.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from level, never from pointer equality alone.
- Dropped write: qw && full && !pop. The entry is discarded and overflow is set to 1. overflow clears only on reset.
- hit_count increments on every qw, accepted or dropped. It saturates at 2^CNT_W−1 and does not wrap.
- Pop when empty is ignored; out_ready is don't-care when empty.
- Reset (synchronous, any cycle, including mid-burst or mid-handshake): pointers, level, hit_count and overflow go to 0. out_valid=0, empty=1, full=0, out_addr/out_data/out_strb=0.
- Contents pending at reset are discarded. A qw in the same cycle as reset is not captured.
- No internal state machine beyond the FIFO control; entry storage may be a register array (DEPTH is small).

Test Plan:
- Reset, then a single store addr=0x0000_1004, wdata=0xDEAD_BEEF, wstrb=4'hF, in_byte_en=1, with out_ready=0 -> next cycle out_valid=1, out_addr=0x1004, out_data=0xDEADBEEF, level=1, hit_count=1; outputs held stable until out_ready=1, then empty=1 the following cycle.
- Stores to 0x0000_0FFC and 0x0000_4000 with in_byte_en forced 1; store with wstrb=0; mem_la_write=0 with in_byte_en=1 -> none captured, hit_count=0, level=0.
- Nine back-to-back stores to 0x1000+4k (k=0..8) with out_ready=0 and DEPTH=8 -> level=8, full=1, overflow=1, hit_count=9. Then drain: 8 entries in order 0x1000..0x101C; the ninth (0x1020) is absent.
- FIFO full, then a qw coinciding with out_ready=1 -> push accepted, level stays 8, overflow stays 0. Drain order is the original entries 2..8 followed by the new one.
- Continuous push and pop for 20 cycles, out_ready=1, addresses 0x2000+4k -> pointers wrap, outputs match in order, and a single entry is stored at a time: level=1, out_valid=1 from the first push onward, with no gaps.
- Five entries queued, then reset asserted for one cycle with a simultaneous qw -> after the edge level=0, out_valid=0, hit_count=0, overflow=0, out_data=0; the qw is not captured.

Source files
------------

// File: rtl/window_write_fifo.sv
// Captures CPU stores into the address window and buffers them for a peripheral.
// Show-ahead FIFO with a saturating hit counter and a sticky overflow flag.
module window_write_fifo #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_1000,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
    parameter int          CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_byte_en,
    input  logic                     mem_la_write,
    input  logic [31:0]              mem_la_addr,
    input  logic [31:0]              mem_la_wdata,
    input  logic [3:0]               mem_la_wstrb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [3:0]               out_strb,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    strb_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          in_window;
    logic          qw;
    logic          pop;
    logic          push;
    logic          drop;

    // The decoder strobe is re-qualified against the bounds here.
    assign in_window = (mem_la_addr >= ADDR_BASE) && (mem_la_addr < ADDR_LIMIT);
    assign qw        = in_byte_en && mem_la_write && (mem_la_wstrb != 4'h0) && in_window;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign out_valid = !empty;

    assign pop       = out_valid && out_ready;
    assign push      = qw && (!full || pop);
    assign drop      = qw && full && !pop;

    // Fields read as zero whenever nothing is queued, including after reset.
    assign out_addr  = empty ? 32'h0 : addr_mem[rd_ptr];
    assign out_data  = empty ? 32'h0 : data_mem[rd_ptr];
    assign out_strb  = empty ? 4'h0  : strb_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= {mem_la_addr[31:2], 2'b00};
            data_mem[wr_ptr] <= mem_la_wdata;
            strb_mem[wr_ptr] <= mem_la_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (qw && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_window_write_fifo.sv
// Directed bench for window_write_fifo: capture filter, ordering,
// full/overflow behaviour, streaming throughput and reset.
module tb_window_write_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_byte_en;
    logic        mem_la_write;
    logic [31:0] mem_la_addr;
    logic [31:0] mem_la_wdata;
    logic [3:0]  mem_la_wstrb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic [15:0] hit_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    window_write_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .in_byte_en   (in_byte_en),
        .mem_la_write (mem_la_write),
        .mem_la_addr  (mem_la_addr),
        .mem_la_wdata (mem_la_wdata),
        .mem_la_wstrb (mem_la_wstrb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_strb     (out_strb),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .hit_count    (hit_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic be, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        in_byte_en   = be;
        mem_la_write = wr;
        mem_la_addr  = a;
        mem_la_wdata = d;
        mem_la_wstrb = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1'b0;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b empty=%b full=%b level=%0d want 0 1 0 0",
                     out_valid, empty, full, level);
        end
        checks++;
        if (hit_count !== 16'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: hit=%0d ovf=%b want 0 0", hit_count, overflow);
        end
        checks++;
        if (out_addr !== 32'h0 || out_data !== 32'h0 || out_strb !== 4'h0) begin
            errors++;
            $display("FAIL reset_fields: addr=%h data=%h strb=%h want 0",
                     out_addr, out_data, out_strb);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        tick();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h1004 || out_data !== 32'hDEAD_BEEF ||
            out_strb !== 4'hF || level !== 4'd1 || hit_count !== 16'd1) begin
            errors++;
            $display("FAIL single_capture: v=%b a=%h d=%h s=%h lvl=%0d hit=%0d want 1 1004 deadbeef f 1 1",
                     out_valid, out_addr, out_data, out_strb, level, hit_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 32'h1004 || out_data !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL single_hold: v=%b a=%h d=%h want 1 1004 deadbeef",
                         out_valid, out_addr, out_data);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || out_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL single_pop: empty=%b v=%b lvl=%0d want 1 0 0", empty, out_valid, level);
        end
    endtask

    task automatic test_align();
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_3FFF, 32'h1234_5678, 4'h2);
        tick();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h3FFC || out_strb !== 4'h2 ||
            out_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL align: v=%b a=%h s=%h d=%h want 1 3ffc 2 12345678",
                     out_valid, out_addr, out_strb, out_data);
        end
    endtask

    task automatic test_reject();
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_0FFC, 32'h1, 4'hF);
        tick();
        drive(1'b1, 1'b1, 32'h0000_4000, 32'h2, 4'hF);
        tick();
        drive(1'b1, 1'b1, 32'h0000_1000, 32'h3, 4'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_1000, 32'h4, 4'hF);
        tick();
        drive(1'b0, 1'b1, 32'h0000_1000, 32'h5, 4'hF);
        tick();
        idle();
        checks++;
        if (hit_count !== 16'd0 || level !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reject: hit=%0d lvl=%0d v=%b want 0 0 0", hit_count, level, out_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, 32'h1000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF);
            tick();
        end
        idle();
        checks++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b1 || hit_count !== 16'd9) begin
            errors++;
            $display("FAIL overflow_state: lvl=%0d full=%b ovf=%b hit=%0d want 8 1 1 9",
                     level, full, overflow, hit_count);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 32'h1000 + 32'(4 * k) ||
                out_data !== 32'hA000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: v=%b a=%h d=%h want 1 %h %h", k,
                         out_valid, out_addr, out_data, 32'h1000 + 32'(4 * k),
                         32'hA000_0000 + 32'(k));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after: empty=%b ovf=%b want 1 1", empty, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_a;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 32'h1000 + 32'(4 * k), 32'hB000_0000 + 32'(k), 4'hF);
            tick();
        end
        drive(1'b1, 1'b1, 32'h0000_1100, 32'hB000_0100, 4'h3);
        out_ready = 1'b1;
        tick();
        idle();
        out_ready = 1'b0;
        checks++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || hit_count !== 16'd9) begin
            errors++;
            $display("FAIL fullpp_state: lvl=%0d full=%b ovf=%b hit=%0d want 8 1 0 9",
                     level, full, overflow, hit_count);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 9; k++) begin
            exp_a = (k == 8) ? 32'h1100 : 32'h1000 + 32'(4 * k);
            checks++;
            if (out_valid !== 1'b1 || out_addr !== exp_a) begin
                errors++;
                $display("FAIL fullpp_drain[%0d]: v=%b a=%h want 1 %h", k, out_valid, out_addr, exp_a);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL fullpp_empty: empty=%b want 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a = 32'h2000 + 32'(4 * k);
            drive(1'b1, 1'b1, a, ~a, 4'hF);
            tick();
            checks++;
            if (out_valid !== 1'b1 || level !== 4'd1 || out_addr !== a || out_data !== ~a) begin
                errors++;
                $display("FAIL stream[%0d]: v=%b lvl=%0d a=%h d=%h want 1 1 %h %h",
                         k, out_valid, level, out_addr, out_data, a, ~a);
            end
        end
        idle();
        tick();
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || hit_count !== 16'd20 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: empty=%b hit=%0d ovf=%b want 1 20 0",
                     empty, hit_count, overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 32'h3000 + 32'(4 * k), 32'hC000_0000 + 32'(k), 4'hF);
            tick();
        end
        checks++;
        if (level !== 4'd5) begin
            errors++;
            $display("FAIL midreset_fill: lvl=%0d want 5", level);
        end
        drive(1'b1, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        out_ready = 1'b0;
        checks++;
        if (level !== 4'd0 || out_valid !== 1'b0 || hit_count !== 16'd0 ||
            overflow !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL midreset: lvl=%0d v=%b hit=%0d ovf=%b d=%h want 0 0 0 0 0",
                     level, out_valid, hit_count, overflow, out_data);
        end
        tick();
        checks++;
        if (empty !== 1'b1 || out_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_after: empty=%b a=%h want 1 0", empty, out_addr);
        end
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        idle();
        tick();
        test_reset();
        test_single();
        test_align();
        test_reject();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
